// File: rtl/rr_onehot_arbiter_if.sv
// Handshake bundle between the requester bank (master) and rr_onehot_arbiter (slave).
// The owner-release strobe is named rel because release is a reserved word.
interface rr_onehot_arbiter_if;
   logic [15:0]       req;
   logic              rel;
   logic [15:0]       gnt;
   logic              gnt_valid;
   logic signed [3:0] gnt_idx;
   logic              timeout;

   modport master (
      output req,
      output rel,
      input  gnt,
      input  gnt_valid,
      input  gnt_idx,
      input  timeout
   );

   modport slave (
      input  req,
      input  rel,
      output gnt,
      output gnt_valid,
      output gnt_idx,
      output timeout
   );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// 16-way round-robin arbiter: registered one-hot grant plus signed owner index (7 - bit position).
// Define ARB_TIMEOUT_EN to build the MAX_HOLD forced-release timer; otherwise timeout is tied low.
module rr_onehot_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input logic                clk,
   input logic                rst_n,
   rr_onehot_arbiter_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e            state_q, state_d;
   logic [3:0]        ptr_q, ptr_d;
   logic [3:0]        owner_q, owner_d;
   logic [15:0]       gnt_q, gnt_d;
   logic              gnt_valid_q, gnt_valid_d;
   logic signed [3:0] gnt_idx_q, gnt_idx_d;

   logic              win_found;
   logic [3:0]        win_pos;
   logic [3:0]        scan_pos;
   logic              rel_cond;
   logic              force_rel;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("MAX_HOLD must be in 1..255");
   end

   // Search downward from ptr with wrap; first set request wins.
   always_comb begin
      win_found = 1'b0;
      win_pos   = '0;
      scan_pos  = '0;
      for (int k = 0; k < 16; k++) begin
         scan_pos = ptr_q - 4'(k);
         if (!win_found && bus.req[scan_pos]) begin
            win_found = 1'b1;
            win_pos   = scan_pos;
         end
      end
   end

   // A dropped request from the owner is treated exactly like an explicit release.
   assign rel_cond = bus.rel | ~bus.req[owner_q];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;
   logic       timeout_q;

   assign force_rel = (state_q == StGrant) && !rel_cond && (hold_q == 8'(MAX_HOLD - 1));

   always_comb begin
      hold_d = hold_q;
      if (state_q != StGrant || rel_cond || force_rel) begin
         hold_d = '0;
      end else begin
         hold_d = hold_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= force_rel;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign force_rel   = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_idx_d   = gnt_idx_q;
      case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d     = StGrant;
               owner_d     = win_pos;
               gnt_d       = 16'h0001 << win_pos;
               gnt_valid_d = 1'b1;
               gnt_idx_d   = $signed(4'd7 - win_pos);
            end
         end
         StGrant: begin
            // Releasing owner drops to lowest priority for the next round.
            if (rel_cond || force_rel) begin
               state_d     = StIdle;
               ptr_d       = owner_q - 4'd1;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               gnt_idx_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= 4'd15;
         owner_q     <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_idx_q   <= gnt_idx_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: rotation table, hand-written corner sequences and a randomized
// run against an owner/pointer reference model. Honours ARB_TIMEOUT_EN like the design.
module tb_rr_onehot_arbiter;

   localparam int unsigned MaxHold = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit ToEn = 1'b1;
`else
   localparam bit ToEn = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   rr_onehot_arbiter_if bus ();

   rr_onehot_arbiter #(
      .MAX_HOLD(MaxHold)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: owner as an integer (-1 when idle), priority pointer, hold count.
   int m_owner;
   int m_ptr;
   int m_hold;
   bit m_timeout;

   function automatic int search(input logic [15:0] r, input int p);
      for (int k = 0; k < 16; k++) begin
         int pos;
         pos = (p - k + 16) % 16;
         if (r[pos]) return pos;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [15:0] r, input logic l);
      int w;
      m_timeout = 1'b0;
      if (m_owner < 0) begin
         w = search(r, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_hold  = 0;
         end
      end else if (l || !r[m_owner]) begin
         m_ptr   = (m_owner + 15) % 16;
         m_owner = -1;
      end else if (ToEn && m_hold == int'(MaxHold) - 1) begin
         m_ptr     = (m_owner + 15) % 16;
         m_owner   = -1;
         m_timeout = 1'b1;
      end else begin
         m_hold++;
      end
   endtask

   function automatic logic [15:0] model_gnt();
      return (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
   endfunction

   function automatic logic signed [3:0] model_idx();
      return (m_owner >= 0) ? 4'(7 - m_owner) : 4'sd0;
   endfunction

   task automatic check(input string name, input logic [15:0] eg, input logic signed [3:0] ei,
                        input logic et);
      n_vec++;
      if (bus.gnt !== eg || bus.gnt_valid !== (eg != 16'h0) || bus.gnt_idx !== ei ||
          bus.timeout !== et) begin
         n_err++;
         $display("FAIL %s: got gnt=%h valid=%b idx=%0d timeout=%b, want gnt=%h valid=%b idx=%0d timeout=%b",
                  name, bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout,
                  eg, (eg != 16'h0), ei, et);
      end
   endtask

   // Drive inputs, take one rising edge, advance the model, settle 1 ns past the edge.
   task automatic step(input logic [15:0] r, input logic l);
      bus.req = r;
      bus.rel = l;
      @(posedge clk);
      model_step(r, l);
      #1;
   endtask

   // Asynchronous reset applied between edges; outputs must clear before any clock edge.
   task automatic do_reset(input string name);
      bus.req = '0;
      bus.rel = 1'b0;
      rst_n   = 1'b0;
      #1;
      check(name, 16'h0000, 4'sd0, 1'b0);
      #1;
      rst_n     = 1'b1;
      m_owner   = -1;
      m_ptr     = 15;
      m_hold    = 0;
      m_timeout = 1'b0;
   endtask

   typedef struct {
      logic [15:0]       req;
      logic              rel;
      logic [15:0]       gnt;
      logic signed [3:0] idx;
   } vec_t;

   vec_t tbl[34];

   initial begin
      logic [15:0] r_cur;
      logic        l_cur;
      n_vec = 0;
      n_err = 0;
      bus.req = '0;
      bus.rel = 1'b0;
      rst_n   = 1'b1;

      // Full rotation with req = FFFFh: owner visible one cycle, released, then idle gap.
      for (int i = 0; i < 17; i++) begin
         tbl[2*i]   = '{req: 16'hFFFF, rel: 1'b0, gnt: 16'h8000 >> (i % 16),
                        idx: 4'(-8 + (i % 16))};
         tbl[2*i+1] = '{req: 16'hFFFF, rel: 1'b1, gnt: 16'h0000, idx: 4'sd0};
      end

      #2;
      do_reset("reset_state");
      for (int k = 0; k < 34; k++) begin
         step(tbl[k].req, tbl[k].rel);
         check($sformatf("rotate_%0d", k), tbl[k].gnt, tbl[k].idx, 1'b0);
      end

      // Wrap-around search: 8000h first from reset, then 0001h.
      do_reset("reset_wrap");
      step(16'h8001, 1'b0);
      check("wrap_first", 16'h8000, -4'sd8, 1'b0);
      step(16'h8001, 1'b1);
      check("wrap_release", 16'h0000, 4'sd0, 1'b0);
      step(16'h8001, 1'b0);
      check("wrap_second", 16'h0001, 4'sd7, 1'b0);

      // Dropped request acts as release and moves ptr to 3.
      do_reset("reset_drop");
      step(16'h0010, 1'b0);
      check("drop_grant", 16'h0010, 4'sd3, 1'b0);
      step(16'h0000, 1'b0);
      check("drop_clear", 16'h0000, 4'sd0, 1'b0);
      step(16'h0018, 1'b0);
      check("drop_ptr3", 16'h0008, 4'sd4, 1'b0);

      // Mid-grant asynchronous reset, then first grant goes to bit 15.
      do_reset("reset_pre_mid");
      step(16'h0100, 1'b0);
      check("mid_grant", 16'h0100, -4'sd1, 1'b0);
      do_reset("reset_mid_grant");
      step(16'hFFFF, 1'b0);
      check("after_mid_reset", 16'h8000, -4'sd8, 1'b0);

      // Release held with no requests: nothing happens, pointer untouched.
      do_reset("reset_rel_idle");
      for (int k = 0; k < 4; k++) begin
         step(16'h0000, 1'b1);
         check($sformatf("rel_idle_%0d", k), 16'h0000, 4'sd0, 1'b0);
      end
      step(16'hFFFF, 1'b0);
      check("rel_idle_grant", 16'h8000, -4'sd8, 1'b0);

      // Grant held with no release for MaxHold cycles.
      do_reset("reset_hold");
      for (int k = 0; k < 4; k++) begin
         step(16'h0001, 1'b0);
         check($sformatf("hold_%0d", k), 16'h0001, 4'sd7, 1'b0);
      end
      step(16'h0001, 1'b0);
`ifdef ARB_TIMEOUT_EN
      check("timeout_clear", 16'h0000, 4'sd0, 1'b1);
      step(16'h0001, 1'b0);
      check("timeout_regrant", 16'h0001, 4'sd7, 1'b0);
      do_reset("reset_rel4");
      for (int k = 0; k < 4; k++) begin
         step(16'h0001, 1'b0);
         check($sformatf("rel4_hold_%0d", k), 16'h0001, 4'sd7, 1'b0);
      end
      step(16'h0001, 1'b1);
      check("rel4_no_timeout", 16'h0000, 4'sd0, 1'b0);
`else
      check("hold_no_timeout", 16'h0001, 4'sd7, 1'b0);
      step(16'h0001, 1'b1);
      check("hold_release", 16'h0000, 4'sd0, 1'b0);
`endif

      // Randomized run against the reference model.
      do_reset("reset_random");
      r_cur = 16'h0000;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            r_cur = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & $urandom);
         end
         l_cur = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 699) == 0) begin
            do_reset("reset_in_random");
         end
         step(r_cur, l_cur);
         check($sformatf("random_%0d", n), model_gnt(), model_idx(), m_timeout);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
